// File: rtl/uart_tx_writer.sv
// uart_tx_writer: register-to-UART write path with a byte FIFO, a PC stall and an 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_writer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        RegtoUART,
    input  logic [31:0]                 write_data,
    output logic                        pc_enable,
    output logic                        txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t         state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           txd_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q, count_d;
    logic           full, push, baud_end, load, unused_hi;
    assign unused_hi = ^write_data[31:8];
    assign full      = count_q == CW'(FIFO_DEPTH);
    assign push      = RegtoUART && !full;
    assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    // The serializer pops whenever it starts a frame, from idle or straight out of the last stop cycle.
    assign load      = (count_q != '0) && (state_q == IDLE || (state_q == STOP && baud_end));
    assign count_d   = count_q + CW'(push) - CW'(load);
    assign pc_enable = !(RegtoUART && full);
    assign txd       = txd_q;
    assign tx_busy   = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    // Byte FIFO: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= write_data[7:0];
                wr_q        <= wr_q + AW'(1);
            end
            if (load) rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end
    // Serializer: every bit lasts CLKS_PER_BIT cycles and txd is driven only from this register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else if (load) begin
            state_q <= START;
            shift_q <= mem_q[rd_q];
            baud_q  <= '0;
            txd_q   <= 1'b0;
        end else if (state_q != IDLE) begin
            baud_q <= baud_end ? '0 : baud_q + BW'(1);
            if (baud_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= ^shift_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[bit_q + 3'd1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_writer.sv
// tb_uart_tx_writer: directed checks of framing, FIFO stall, reset truncation and idle pc_enable.
`timescale 1ns/1ps
module tb_uart_tx_writer;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic        clk = 1'b0, reset = 1'b1, RegtoUART = 1'b0;
    logic [31:0] write_data = '0;
    logic        pc_enable, txd, tx_busy;
    logic [2:0]  fifo_count;
    int          tests = 0, fails = 0;
    int          st, lows;
    logic [2:0]  lc, rc;
    always #5 clk = ~clk;
    uart_tx_writer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .RegtoUART(RegtoUART), .write_data(write_data),
        .pc_enable(pc_enable), .txd(txd), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic push(input logic [31:0] w, output int stall, output logic [2:0] last_cnt, output logic [2:0] rel_cnt);
        RegtoUART = 1'b1;
        write_data = w;
        #1;
        stall = 0;
        last_cnt = fifo_count;
        while (!pc_enable && stall < 200) begin
            last_cnt = fifo_count;
            @(negedge clk);
            #1;
            stall++;
        end
        rel_cnt = fifo_count;
        @(negedge clk);
        RegtoUART = 1'b0;
    endtask
    // Waits (bounded) for a start bit, then checks every cycle of the frame; returns one negedge past it.
    task automatic rx_frame(input string tag, input logic [7:0] b, input int budget);
        logic [10:0] bits;
        int n;
        bits = (NB == 11) ? {1'b1, ^b, b, 1'b0} : {2'b11, b, 1'b0};
        n = 0;
        while (txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < NB; k++)
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s_bit%0d", tag, k), txd, bits[k]);
                check($sformatf("%s_busy%0d", tag, k), tx_busy, 1);
                @(negedge clk);
            end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge clk);
        check("rst_pc", pc_enable, 1);
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_cnt", fifo_count, 0);
        reset = 1'b0;
        @(negedge clk);
        // single byte
        push(32'h1234_5641, st, lc, rc);
        check("t1_stall", st, 0);
        check("t1_txd_hi", txd, 1);
        check("t1_cnt1", fifo_count, 1);
        @(negedge clk);
        check("t1_txd_lo", txd, 0);
        check("t1_cnt0", fifo_count, 0);
        rx_frame("t1", 8'h41, 0);
        check("t1_busy_end", tx_busy, 0);
        check("t1_txd_end", txd, 1);
        // full stall with simultaneous pop, back-to-back frames
        repeat (3) @(negedge clk);
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    push(i, st, lc, rc);
                    check("t2_nostall", st, 0);
                end
                check("t2_full", fifo_count, 4);
                push(6, st, lc, rc);
                check("t2_stall_len", st, 4 * NB - 3);
                check("t2_cnt_before", lc, 4);
                check("t2_cnt_pop", rc, 3);
                check("t2_cnt_after", fifo_count, 4);
            end
            begin
                rx_frame("t2_f1", 8'h01, 10);
                for (int j = 2; j <= 6; j++) rx_frame($sformatf("t2_f%0d", j), 8'(j), 0);
            end
        join
        check("t2_busy_end", tx_busy, 0);
        check("t2_cnt_end", fifo_count, 0);
        // reset mid-frame
        repeat (3) @(negedge clk);
        push(32'hA5, st, lc, rc);
        push(32'h11, st, lc, rc);
        push(32'h22, st, lc, rc);
        repeat (16) @(negedge clk);
        check("t3_d3", txd, 0);
        check("t3_cnt", fifo_count, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t3_txd", txd, 1);
        check("t3_cnt0", fifo_count, 0);
        check("t3_busy", tx_busy, 0);
        check("t3_pc", pc_enable, 1);
        reset = 1'b0;
        lows = 0;
        repeat (20 * CPB) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("t3_no_start", lows, 0);
        // idle pc_enable with full FIFO
        for (int i = 0; i < 5; i++) push(32'h30 + i, st, lc, rc);
        check("t4_full", fifo_count, 4);
        RegtoUART = 1'b1;
        #1;
        check("t4_stall", pc_enable, 0);
        RegtoUART = 1'b0;
        #1;
        lows = 0;
        repeat (100) begin
            if (pc_enable !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t4_idle_pc", lows, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`ifdef UART_TX_PARITY_EN
        push(32'h07, st, lc, rc);
        rx_frame("t5", 8'h07, 4);
        check("t5_busy_end", tx_busy, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
